reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_pkg.sv | 18 +
 rtl/reset_sync.sv | 22 ++
 rtl/reset_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/reset_pkg.sv
// Shared definitions for the reset sequencer.
// State codes and default timing constants.
package reset_pkg;

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      WAIT_LOCK = 3'd1,
      REL_MEM   = 3'd2,
      REL_VIDEO = 3'd3,
      RUN       = 3'd4,
      CPU_ONLY  = 3'd5
   } state_t;

   localparam int STAGE_DELAY_DEF = 1000;
   localparam int LOCK_FILTER_DEF = 16;
   localparam int CNT_W           = 16;

endpackage

// File: rtl/reset_sync.sv
// Reset synchroniser: asserts asynchronously,
// releases on the 2nd rising clk edge.
module reset_sync (
   input  logic clk,
   input  logic reset_in,
   output logic reset_out
);

   logic meta;

   // two-flop shift of a constant 1, cleared by the raw reset
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         meta      <= 1'b0;
         reset_out <= 1'b0;
      end else begin
         meta      <= 1'b1;
         reset_out <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: memory, then video, then CPU,
// gated by a filtered PLL lock, with a CPU-only soft reset.
module reset_sequencer
   import reset_pkg::*;
#(
   parameter int STAGE_DELAY = STAGE_DELAY_DEF,
   parameter int LOCK_FILTER = LOCK_FILTER_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic       soft_req,
   output logic       reset_mem_n,
   output logic       reset_video_n,
   output logic       reset_cpu_n,
   output logic       ready,
   output logic [2:0] stage
);

   if (STAGE_DELAY < 1 || STAGE_DELAY > 65535) begin : g_bad_delay
      $error("STAGE_DELAY must be in 1..65535");
   end
   if (LOCK_FILTER < 1 || LOCK_FILTER > 65535) begin : g_bad_filter
      $error("LOCK_FILTER must be in 1..65535");
   end

   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DELAY - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);

   logic             rst_s;
   logic             lock_m;
   logic             lock_s;
   state_t           state;
   state_t           next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             mem_d;
   logic             video_d;
   logic             run_d;

   reset_sync u_sync (
      .clk       (clk),
      .reset_in  (reset),
      .reset_out (rst_s)
   );

   // double-flop the asynchronous lock indication
   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_locked;
         lock_s <= lock_m;
      end
   end

   // next state, saturating counter and output decode
   always_comb begin
      next     = state;
      cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;
      unique case (state)
         HOLD: next = WAIT_LOCK;
         WAIT_LOCK: begin
            if (!lock_s)
               cnt_next = '0;
            else if (cnt == LOCK_LAST)
               next = REL_MEM;
         end
         REL_MEM: begin
            if (!lock_s)
               next = HOLD;
            else if (cnt == DLY_LAST)
               next = REL_VIDEO;
         end
         REL_VIDEO: begin
            if (!lock_s)
               next = HOLD;
            else if (cnt == DLY_LAST)
               next = RUN;
         end
         RUN: begin
            if (!lock_s)
               next = HOLD;
            else if (soft_req)
               next = CPU_ONLY;
         end
         CPU_ONLY: begin
            if (!lock_s)
               next = HOLD;
            else if (cnt == DLY_LAST)
               next = RUN;
         end
         default: next = HOLD;
      endcase
      if (next != state)
         cnt_next = '0;
      mem_d   = (next == REL_MEM) || (next == REL_VIDEO) ||
                (next == RUN) || (next == CPU_ONLY);
      video_d = (next == REL_VIDEO) || (next == RUN) ||
                (next == CPU_ONLY);
      run_d   = (next == RUN);
   end

   // state, counter and registered outputs
   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         state         <= HOLD;
         cnt           <= '0;
         reset_mem_n   <= 1'b0;
         reset_video_n <= 1'b0;
         reset_cpu_n   <= 1'b0;
         ready         <= 1'b0;
      end else begin
         state         <= next;
         cnt           <= cnt_next;
         reset_mem_n   <= mem_d;
         reset_video_n <= video_d;
         reset_cpu_n   <= run_d;
         ready         <= run_d;
      end
   end

   assign stage = state;

endmodule
